// File: rtl/dbus_req_ctrl_if.sv
// Data-side bus request/response bundle between the MEM-stage controller and the bridge.
// master: controller drives request; slave: bridge accepts and returns in-order responses.
interface dbus_req_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  dbus_valid;
  logic                  dbus_ready;
  logic                  dbus_wr;
  logic [ADDR_W-1:0]     dbus_addr;
  logic [DATA_W-1:0]     dbus_wdata;
  logic [DATA_W/8-1:0]   dbus_wstrb;
  logic                  dbus_resp;
  logic [DATA_W-1:0]     dbus_rdata;

  modport master (
    output dbus_valid,
    output dbus_wr,
    output dbus_addr,
    output dbus_wdata,
    output dbus_wstrb,
    input  dbus_ready,
    input  dbus_resp,
    input  dbus_rdata
  );

  modport slave (
    input  dbus_valid,
    input  dbus_wr,
    input  dbus_addr,
    input  dbus_wdata,
    input  dbus_wstrb,
    output dbus_ready,
    output dbus_resp,
    output dbus_rdata
  );
endinterface

// File: rtl/dbus_req_ctrl.sv
// MEM-stage data-bus request controller: TLB/flush gating, registered valid/ready
// request, in-order response flag FIFO, load data return and pipeline stall.
// Ports: clk, rst (sync, high); mem_* op; tlbd_*; exr_valid; dbus (master);
// rdata_valid/rdata load return; tlb_exc, stall (combinational).
module dbus_req_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                tlbd_ready,
  input  logic                tlbd_miss,
  input  logic                exr_valid,
  dbus_req_ctrl_if.master     dbus,
  output logic                rdata_valid,
  output logic [DATA_W-1:0]   rdata,
  output logic                tlb_exc,
  output logic                stall
);

  localparam int SW = DATA_W / 8;
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    KREQ
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [MAX_OUTST-1:0] rd_q;
  logic [MAX_OUTST-1:0] kill_q;
  logic [PW-1:0]        head_q;
  logic [PW-1:0]        tail_q;
  logic [CW-1:0]        cnt_q;

  logic op;
  logic full;
  logic issue;
  logic hs;
  logic push;
  logic pop;
  logic push_kill;
  logic head_rd;
  logic head_kill;
  logic done;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    if (p == PW'(MAX_OUTST - 1)) begin
      nxt = '0;
    end else begin
      nxt = p + PW'(1);
    end
  endfunction

  assign op    = mem_read | mem_write;
  assign full  = (cnt_q == CW'(MAX_OUTST));
  assign hs    = dbus.dbus_valid & dbus.dbus_ready;
  assign issue = (state_q == IDLE) & op & tlbd_ready
               & ~tlbd_miss & ~exr_valid & ~full;

  // Every accepted request owns one response slot.
  assign push = hs;
  // A response arriving with nothing tracked is dropped.
  assign pop  = dbus.dbus_resp & (cnt_q != '0);

  // A request accepted while flushed, or after its op was flushed,
  // must never return data to the pipeline.
  assign push_kill = exr_valid | (state_q == KREQ);

  assign head_rd   = rd_q[head_q];
  assign head_kill = kill_q[head_q];

  assign tlb_exc = (state_q == IDLE) & op & tlbd_ready
                 & tlbd_miss & ~exr_valid;

  // Completion is tied to the state that owns the current op so that
  // handshakes of killed requests never release a younger op.
  assign done = ((state_q == REQ) & hs & dbus.dbus_wr)
              | ((state_q == WAIT) & rdata_valid);

  assign stall = op & ~exr_valid & ~tlb_exc & ~done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // WAIT is left on the data-return cycle rather than the response
  // cycle, so the completing op is never re-issued from IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (hs) begin
          if (dbus.dbus_wr | exr_valid) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end else if (exr_valid) begin
          state_d = KREQ;
        end
      end
      WAIT: begin
        if (exr_valid | rdata_valid) begin
          state_d = IDLE;
        end
      end
      KREQ: begin
        if (hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbus.dbus_valid <= 1'b0;
      dbus.dbus_wr    <= 1'b0;
      dbus.dbus_addr  <= '0;
      dbus.dbus_wdata <= '0;
      dbus.dbus_wstrb <= '0;
    end else if (issue) begin
      dbus.dbus_valid <= 1'b1;
      dbus.dbus_wr    <= mem_write;
      dbus.dbus_addr  <= mem_addr;
      dbus.dbus_wdata <= mem_wdata;
      dbus.dbus_wstrb <= mem_write ? mem_wstrb : SW'(0);
    end else if (hs) begin
      dbus.dbus_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q   <= '0;
      kill_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (exr_valid) begin
        kill_q <= '1;
      end
      if (push) begin
        rd_q[tail_q]   <= ~dbus.dbus_wr;
        kill_q[tail_q] <= push_kill;
        tail_q         <= nxt(tail_q);
      end
      if (pop) begin
        head_q <= nxt(head_q);
      end
      if (push & ~pop) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (pop & ~push) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  // A flush in the response cycle also suppresses the return.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_valid <= 1'b0;
      rdata       <= '0;
    end else begin
      rdata_valid <= pop & head_rd & ~head_kill & ~exr_valid;
      if (pop & head_rd & ~head_kill & ~exr_valid) begin
        rdata <= dbus.dbus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dbus_req_ctrl.sv
// Directed bench for dbus_req_ctrl: load, stalled store, outstanding limit,
// killed request, TLB miss/not-ready and reset in WAIT.
module tb_dbus_req_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          tlbd_ready;
  logic          tlbd_miss;
  logic          exr_valid;
  logic          rdata_valid;
  logic [DW-1:0] rdata;
  logic          tlb_exc;
  logic          stall;

  int total;
  int bad;

  dbus_req_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dbus_req_ctrl #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .MAX_OUTST(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .tlbd_ready(tlbd_ready),
    .tlbd_miss(tlbd_miss),
    .exr_valid(exr_valid),
    .dbus(bus.master),
    .rdata_valid(rdata_valid),
    .rdata(rdata),
    .tlb_exc(tlb_exc),
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    tlbd_ready = 1'b1;
    tlbd_miss = 1'b0;
    exr_valid = 1'b0;
    bus.dbus_ready = 1'b0;
    bus.dbus_resp = 1'b0;
    bus.dbus_rdata = '0;
    tick();
    tick();
    #1;
    chk("rst_valid", 64'(bus.dbus_valid), 64'd0);
    chk("rst_wr", 64'(bus.dbus_wr), 64'd0);
    chk("rst_addr", 64'(bus.dbus_addr), 64'd0);
    chk("rst_wstrb", 64'(bus.dbus_wstrb), 64'd0);
    chk("rst_rvalid", 64'(rdata_valid), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    rst = 1'b0;
    tick();

    // load, immediate accept, response 3 cycles after handshake
    mem_read = 1'b1;
    mem_addr = 32'h100;
    bus.dbus_ready = 1'b1;
    #1;
    chk("ld_stall_idle", 64'(stall), 64'd1);
    chk("ld_valid_idle", 64'(bus.dbus_valid), 64'd0);
    tick();
    #1;
    chk("ld_valid", 64'(bus.dbus_valid), 64'd1);
    chk("ld_addr", 64'(bus.dbus_addr), 64'h100);
    chk("ld_wr", 64'(bus.dbus_wr), 64'd0);
    chk("ld_wstrb", 64'(bus.dbus_wstrb), 64'd0);
    chk("ld_stall_req", 64'(stall), 64'd1);
    tick();
    bus.dbus_ready = 1'b0;
    #1;
    chk("ld_valid_drop", 64'(bus.dbus_valid), 64'd0);
    tick();
    tick();
    bus.dbus_resp = 1'b1;
    bus.dbus_rdata = 32'h12345678;
    #1;
    chk("ld_stall_resp", 64'(stall), 64'd1);
    tick();
    bus.dbus_resp = 1'b0;
    bus.dbus_rdata = '0;
    #1;
    chk("ld_rvalid", 64'(rdata_valid), 64'd1);
    chk("ld_rdata", 64'(rdata), 64'h12345678);
    chk("ld_stall_done", 64'(stall), 64'd0);
    tick();
    mem_read = 1'b0;
    #1;
    chk("ld_rvalid_pulse", 64'(rdata_valid), 64'd0);
    chk("ld_no_reissue", 64'(bus.dbus_valid), 64'd0);

    // store held by bridge for 4 cycles
    mem_write = 1'b1;
    mem_addr = 32'h200;
    mem_wdata = 32'hDEADBEEF;
    mem_wstrb = 4'hF;
    #1;
    chk("st_stall_idle", 64'(stall), 64'd1);
    tick();
    mem_addr = 32'h999;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("st_hold_valid", 64'(bus.dbus_valid), 64'd1);
      chk("st_hold_addr", 64'(bus.dbus_addr), 64'h200);
      chk("st_hold_wdata", 64'(bus.dbus_wdata), 64'hDEADBEEF);
      chk("st_hold_wstrb", 64'(bus.dbus_wstrb), 64'hF);
      chk("st_hold_stall", 64'(stall), 64'd1);
      tick();
    end
    bus.dbus_ready = 1'b1;
    #1;
    chk("st_wr", 64'(bus.dbus_wr), 64'd1);
    chk("st_stall_hs", 64'(stall), 64'd0);
    tick();
    mem_write = 1'b0;
    bus.dbus_ready = 1'b0;
    #1;
    chk("st_valid_after", 64'(bus.dbus_valid), 64'd0);
    tick();
    bus.dbus_resp = 1'b1;
    tick();
    bus.dbus_resp = 1'b0;
    #1;
    chk("st_no_rvalid", 64'(rdata_valid), 64'd0);

    // two posted stores fill the tracker; a load must wait
    mem_write = 1'b1;
    mem_addr = 32'h300;
    mem_wdata = 32'h1;
    mem_wstrb = 4'h3;
    bus.dbus_ready = 1'b1;
    tick();
    #1;
    chk("mo_s1_stall", 64'(stall), 64'd0);
    tick();
    mem_addr = 32'h304;
    mem_wdata = 32'h2;
    #1;
    chk("mo_gap_stall", 64'(stall), 64'd1);
    tick();
    #1;
    chk("mo_s2_addr", 64'(bus.dbus_addr), 64'h304);
    chk("mo_s2_stall", 64'(stall), 64'd0);
    tick();
    mem_write = 1'b0;
    mem_read = 1'b1;
    mem_addr = 32'h308;
    #1;
    chk("mo_full_stall", 64'(stall), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("mo_blocked", 64'(bus.dbus_valid), 64'd0);
    end
    bus.dbus_resp = 1'b1;
    tick();
    bus.dbus_resp = 1'b0;
    #1;
    chk("mo_s1_rvalid", 64'(rdata_valid), 64'd0);
    chk("mo_valid_gap", 64'(bus.dbus_valid), 64'd0);
    tick();
    #1;
    chk("mo_ld_valid", 64'(bus.dbus_valid), 64'd1);
    chk("mo_ld_addr", 64'(bus.dbus_addr), 64'h308);
    tick();
    bus.dbus_ready = 1'b0;
    bus.dbus_resp = 1'b1;
    tick();
    bus.dbus_resp = 1'b0;
    #1;
    chk("mo_s2_rvalid", 64'(rdata_valid), 64'd0);
    chk("mo_ld_stall", 64'(stall), 64'd1);
    bus.dbus_resp = 1'b1;
    bus.dbus_rdata = 32'hCAFEF00D;
    tick();
    bus.dbus_resp = 1'b0;
    #1;
    chk("mo_ld_rvalid", 64'(rdata_valid), 64'd1);
    chk("mo_ld_rdata", 64'(rdata), 64'hCAFEF00D);
    chk("mo_ld_done", 64'(stall), 64'd0);
    tick();
    mem_read = 1'b0;

    // load flushed before accept: killed request held, data dropped
    mem_read = 1'b1;
    mem_addr = 32'h400;
    tick();
    #1;
    chk("kl_valid", 64'(bus.dbus_valid), 64'd1);
    exr_valid = 1'b1;
    #1;
    chk("kl_stall_exr", 64'(stall), 64'd0);
    tick();
    exr_valid = 1'b0;
    mem_addr = 32'h500;
    #1;
    chk("kl_hold_valid", 64'(bus.dbus_valid), 64'd1);
    chk("kl_hold_addr", 64'(bus.dbus_addr), 64'h400);
    chk("kl_new_stall", 64'(stall), 64'd1);
    tick();
    #1;
    chk("kl_hold_addr2", 64'(bus.dbus_addr), 64'h400);
    bus.dbus_ready = 1'b1;
    #1;
    chk("kl_stall_hs", 64'(stall), 64'd1);
    tick();
    #1;
    chk("kl_idle_valid", 64'(bus.dbus_valid), 64'd0);
    tick();
    #1;
    chk("kl_new_valid", 64'(bus.dbus_valid), 64'd1);
    chk("kl_new_addr", 64'(bus.dbus_addr), 64'h500);
    tick();
    bus.dbus_ready = 1'b0;
    bus.dbus_resp = 1'b1;
    bus.dbus_rdata = 32'hBAD;
    tick();
    bus.dbus_resp = 1'b0;
    #1;
    chk("kl_drop", 64'(rdata_valid), 64'd0);
    chk("kl_drop_stall", 64'(stall), 64'd1);
    bus.dbus_resp = 1'b1;
    bus.dbus_rdata = 32'h55AA;
    tick();
    bus.dbus_resp = 1'b0;
    #1;
    chk("kl_new_rvalid", 64'(rdata_valid), 64'd1);
    chk("kl_new_rdata", 64'(rdata), 64'h55AA);
    tick();
    mem_read = 1'b0;

    // TLB miss and TLB not ready
    mem_read = 1'b1;
    mem_addr = 32'h700;
    tlbd_miss = 1'b1;
    #1;
    chk("tlb_exc", 64'(tlb_exc), 64'd1);
    chk("tlb_stall", 64'(stall), 64'd0);
    tick();
    #1;
    chk("tlb_no_req", 64'(bus.dbus_valid), 64'd0);
    tlbd_miss = 1'b0;
    tlbd_ready = 1'b0;
    #1;
    chk("tlbnr_exc", 64'(tlb_exc), 64'd0);
    chk("tlbnr_stall", 64'(stall), 64'd1);
    tick();
    #1;
    chk("tlbnr_no_req", 64'(bus.dbus_valid), 64'd0);
    mem_read = 1'b0;
    tlbd_ready = 1'b1;

    // reset while waiting for a load response
    tick();
    mem_read = 1'b1;
    mem_addr = 32'h600;
    bus.dbus_ready = 1'b1;
    tick();
    tick();
    bus.dbus_ready = 1'b0;
    rst = 1'b1;
    mem_read = 1'b0;
    tick();
    #1;
    chk("wr_rst_valid", 64'(bus.dbus_valid), 64'd0);
    chk("wr_rst_addr", 64'(bus.dbus_addr), 64'd0);
    chk("wr_rst_rvalid", 64'(rdata_valid), 64'd0);
    chk("wr_rst_rdata", 64'(rdata), 64'd0);
    chk("wr_rst_stall", 64'(stall), 64'd0);
    rst = 1'b0;
    bus.dbus_resp = 1'b1;
    bus.dbus_rdata = 32'hFFFF;
    tick();
    bus.dbus_resp = 1'b0;
    #1;
    chk("stray_resp", 64'(rdata_valid), 64'd0);
    mem_read = 1'b1;
    mem_addr = 32'h610;
    bus.dbus_ready = 1'b1;
    tick();
    tick();
    bus.dbus_ready = 1'b0;
    bus.dbus_resp = 1'b1;
    bus.dbus_rdata = 32'h77;
    tick();
    bus.dbus_resp = 1'b0;
    #1;
    chk("post_rst_rvalid", 64'(rdata_valid), 64'd1);
    chk("post_rst_rdata", 64'(rdata), 64'h77);
    tick();
    mem_read = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
